synaptic_current_accum: RTL

//  Upstream stage of the LIF neuron. Once per timestep it sums the weights of all

---
 rtl/synaptic_current_accum_pkg.sv | 38 +++
 rtl/synaptic_current_accum_if.sv | 35 +++
 rtl/synaptic_current_accum_weight_rf.sv | 54 +++++
 rtl/synaptic_current_accum.sv | 124 ++++++++++++
 4 files changed

// File: rtl/synaptic_current_accum_pkg.sv
// Shared definitions for the synaptic current accumulator: default sizes,
// FSM state encodings, accumulator width formula and output clamp.
package synaptic_current_accum_pkg;

    localparam int N_SYN_DEF   = 8;
    localparam int W_WIDTH_DEF = 8;
    localparam int CUR_W_DEF   = 8;

    // FSM state encodings (IDLE -> ACCUM -> DONE -> IDLE)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Accumulator width: one extra bit per doubling of synapse count plus a
    // guard bit, so summing N_SYN extreme weights can never overflow.
    function automatic int acc_width(input int n_syn, input int w_width);
        return w_width + $clog2(n_syn) + 1;
    endfunction

    localparam int ACC_W_DEF = acc_width(N_SYN_DEF, W_WIDTH_DEF);

    // Saturate a signed sum into the unsigned range 0 .. 2^cur_w-1.
    // The caller sign-extends its accumulator to 32 bits and truncates the
    // result back to its own current width.
    function automatic logic [31:0] clamp_to_current(input logic signed [31:0] acc,
                                                     input int                 cur_w);
        int max_val;
        max_val = (1 << cur_w) - 1;
        if (acc < 0) begin
            return '0;
        end else if (acc > max_val) begin
            return 32'(max_val);
        end else begin
            return 32'(acc);
        end
    endfunction

endpackage

// File: rtl/synaptic_current_accum_if.sv
// Bundle of control, weight-write and result signals between the neuron
// front end (master) and the synaptic current accumulator (slave).
interface synaptic_current_accum_if
    import synaptic_current_accum_pkg::*;
#(
    parameter int N_SYN   = N_SYN_DEF,
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int CUR_W   = CUR_W_DEF
);
    localparam int ADDR_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    // Stimulus side
    logic                       step;
    logic [N_SYN-1:0]           pre_spike;
    logic                       w_we;
    logic [ADDR_W-1:0]          w_addr;
    logic signed [W_WIDTH-1:0]  w_data;

    // Result side
    logic [CUR_W-1:0]           input_current;
    logic                       current_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output step, pre_spike, w_we, w_addr, w_data,
        input  input_current, current_valid, busy, overrun
    );

    modport slave (
        input  step, pre_spike, w_we, w_addr, w_data,
        output input_current, current_valid, busy, overrun
    );

endinterface

// File: rtl/synaptic_current_accum_weight_rf.sv
// N_SYN x W_WIDTH signed weight register file. One write port taking effect
// at the clock edge, one combinational read port, so a read and a write of
// the same entry in one cycle returns the old value.
module synapse_weight_rf
    import synaptic_current_accum_pkg::*;
#(
    parameter int N_SYN   = N_SYN_DEF,
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int ADDR_W  = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic signed [W_WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    output logic signed [W_WIDTH-1:0]  rd_data_o
);

    // All entries packed side by side so the read mux can slice them
    logic [N_SYN*W_WIDTH-1:0] w_flat;

    genvar gi;
    generate
        for (gi = 0; gi < N_SYN; gi++) begin : gen_entry
            logic signed [W_WIDTH-1:0] w_q;
            logic                      hit;

            assign hit = we_i && (wr_addr_i == ADDR_W'(gi));

            // Per-entry storage: cleared on reset, loaded when addressed
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    w_q <= '0;
                end else if (hit) begin
                    w_q <= wr_data_i;
                end
            end

            assign w_flat[gi*W_WIDTH +: W_WIDTH] = w_q;
        end
    endgenerate

    // Combinational read mux; out-of-range addresses read as zero
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                rd_data_o = w_flat[i*W_WIDTH +: W_WIDTH];
            end
        end
    end

endmodule

// File: rtl/synaptic_current_accum.sv
// Synaptic current accumulator: once per timestep, serially sums the signed
// weights of spiking presynaptic inputs (one synapse per clock, one adder)
// and drives a saturated unsigned input current to the LIF neuron.
module synaptic_current_accum
    import synaptic_current_accum_pkg::*;
#(
    parameter int N_SYN   = N_SYN_DEF,
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int CUR_W   = CUR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    synaptic_current_accum_if.slave   bus
);

    localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam int ACC_W = acc_width(N_SYN, W_WIDTH);

    logic [1:0]                 state_q,   state_d;
    logic [IDX_W-1:0]           idx_q,     idx_d;
    logic [N_SYN-1:0]           snap_q,    snap_d;
    logic signed [ACC_W-1:0]    acc_q,     acc_d;
    logic [CUR_W-1:0]           cur_q,     cur_d;
    logic                       valid_q,   valid_d;
    logic                       overrun_q, overrun_d;

    logic signed [W_WIDTH-1:0]  w_rd;
    logic signed [ACC_W-1:0]    w_ext;
    logic signed [31:0]         acc_ext;
    logic                       last_idx;

    synapse_weight_rf #(
        .N_SYN   (N_SYN),
        .W_WIDTH (W_WIDTH),
        .ADDR_W  (IDX_W)
    ) u_weight_rf (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.w_we),
        .wr_addr_i (bus.w_addr),
        .wr_data_i (bus.w_data),
        .rd_addr_i (idx_q),
        .rd_data_o (w_rd)
    );

    assign w_ext    = {{(ACC_W-W_WIDTH){w_rd[W_WIDTH-1]}}, w_rd};
    assign acc_ext  = {{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign last_idx = (idx_q == IDX_W'(N_SYN - 1));

    // Next-state logic: FSM sequencing, serial accumulate, clamp on DONE
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        acc_d     = acc_q;
        cur_d     = cur_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.step) begin
                    snap_d  = bus.pre_spike;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // The weight read here is the pre-edge value, so a write to
                // the current index lands after it has been summed.
                if (snap_q[idx_q]) begin
                    acc_d = acc_q + w_ext;
                end
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                cur_d   = CUR_W'(clamp_to_current(acc_ext, CUR_W));
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A step arriving mid-accumulation is dropped and flagged
        if (bus.step && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers; reset aborts any partial sum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            acc_q     <= '0;
            cur_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            acc_q     <= acc_d;
            cur_q     <= cur_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.input_current = cur_q;
    assign bus.current_valid = valid_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.overrun       = overrun_q;

endmodule
